// File: rtl/pq_coeff_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pq_coeff_pkg
//  Purpose  : Shared constants, size derivations and FSM state type for the
//             PQ coefficient register file.
//  Revision : 1.0 - initial release
// ============================================================================
package pq_coeff_pkg;

    // Default NTT address width and word width.
    localparam int c_addr_width = 6;
    localparam int c_data_width = 32;

    // One NTT address bit selects the coefficient half, the rest select the word.
    function automatic int num_words_f(input int addr_width);
        return 2 ** (addr_width - 1);
    endfunction

    // Two coefficients are packed per word.
    function automatic int coef_w_f(input int data_width);
        return data_width / 2;
    endfunction

    localparam int c_coef_w = coef_w_f(c_data_width);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2
    } pq_state_e;

endpackage
`default_nettype wire

// File: rtl/pq_coeff_reduce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pq_coeff_reduce
//  Purpose  : Single conditional subtraction bringing a coefficient in [0, 2q)
//             into [0, q). Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module pq_coeff_reduce
    import pq_coeff_pkg::*;
#(
    parameter int W = c_coef_w
) (
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_modulus,
    output logic [W-1:0] o_r
);

    assign o_r = (i_c >= i_modulus) ? (i_c - i_modulus) : i_c;

endmodule
`default_nettype wire

// File: rtl/pq_coeff_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pq_coeff_regfile
//  Purpose  : 32 x 32-bit PQ register file feeding the NTT accelerator, with a
//             streaming coefficient load sequencer and unload sequencer.
//             Each word holds {odd coefficient, even coefficient}.
//  Options  : PQ_COEFF_REDUCE_EN - reduce load coefficients by one
//             conditional subtraction of 'modulus' before storing.
//  Revision : 1.0 - initial release
// ============================================================================
module pq_coeff_regfile
    import pq_coeff_pkg::*;
#(
    parameter  int ADDR_WIDTH = c_addr_width,
    parameter  int DATA_WIDTH = c_data_width,
    localparam int NUM_WORDS  = num_words_f(ADDR_WIDTH),
    localparam int COEF_W     = coef_w_f(DATA_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COEF_W-1:0]               modulus,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] wdata_pq_i,
    input  logic [NUM_WORDS-1:0]            we_pq_i,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] rdata_pq_o,
    input  logic                            load_start_i,
    input  logic                            load_valid_i,
    input  logic [COEF_W-1:0]               load_data_i,
    output logic                            load_ready_o,
    input  logic                            unload_start_i,
    output logic                            unload_valid_o,
    output logic [COEF_W-1:0]               unload_data_o,
    input  logic                            unload_ready_i,
    output logic                            busy_o,
    output logic                            done_o
);

    pq_state_e             r_state;
    pq_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [COEF_W-1:0]     r_lo;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

    logic [ADDR_WIDTH-2:0] w_idx;
    logic [DATA_WIDTH-1:0] w_word;
    logic [COEF_W-1:0]     w_coef;
    logic                  w_load_beat;
    logic                  w_unload_beat;
    logic                  w_last_beat;
    logic                  w_start;

    // Counter LSB picks the coefficient half, the upper bits pick the word.
    assign w_idx         = r_cnt[ADDR_WIDTH-1:1];
    assign w_word        = r_mem[w_idx];
    assign w_load_beat   = (r_state == LOAD) && load_valid_i;
    assign w_unload_beat = (r_state == UNLOAD) && unload_ready_i;
    assign w_last_beat   = (w_load_beat || w_unload_beat) && (&r_cnt);
    assign w_start       = load_start_i || unload_start_i;

`ifdef PQ_COEFF_REDUCE_EN
    pq_coeff_reduce #(
        .W (COEF_W)
    ) u_reduce (
        .i_c       (load_data_i),
        .i_modulus (modulus),
        .o_r       (w_coef)
    );
`else
    logic w_unused_modulus;
    assign w_coef           = load_data_i;
    assign w_unused_modulus = ^modulus;
`endif

    assign load_ready_o   = (r_state == LOAD);
    assign unload_valid_o = (r_state == UNLOAD);
    assign busy_o         = (r_state != IDLE);
    assign done_o         = r_done;
    assign unload_data_o  = (r_state != UNLOAD) ? '0 :
                            (r_cnt[0] ? w_word[DATA_WIDTH-1:COEF_W] : w_word[COEF_W-1:0]);

    // The array is exposed as-is to the NTT: no read logic, no latency.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_rdata
        assign rdata_pq_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_mem[gi];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: load wins a simultaneous start; starts are ignored while busy.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (load_start_i) begin
                    w_state_nxt = LOAD;
                end else if (unload_start_i) begin
                    w_state_nxt = UNLOAD;
                end
            end
            LOAD, UNLOAD: begin
                if (w_last_beat) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Beat counter, even-coefficient staging register and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_beat;
            if (r_state == IDLE && w_start) begin
                r_cnt <= '0;
            end
            if (w_load_beat || w_unload_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load_beat && !r_cnt[0]) begin
                r_lo <= w_coef;
            end
        end
    end

    // Word array: NTT owns it in IDLE, the load sequencer writes completed pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == IDLE) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (we_pq_i[i]) begin
                    r_mem[i] <= wdata_pq_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end else if (w_load_beat && r_cnt[0]) begin
            r_mem[w_idx] <= {w_coef, r_lo};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pq_coeff_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pq_coeff_regfile
//  Purpose  : Self-checking bench for pq_coeff_regfile. Unload coefficients
//             are checked through a scoreboard queue popped by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pq_coeff_regfile;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NW = 32;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     modulus;
    logic [NW*DW-1:0]  wdata_pq_i;
    logic [NW-1:0]     we_pq_i;
    logic [NW*DW-1:0]  rdata_pq_o;
    logic              load_start_i;
    logic              load_valid_i;
    logic [CW-1:0]     load_data_i;
    logic              load_ready_o;
    logic              unload_start_i;
    logic              unload_valid_o;
    logic [CW-1:0]     unload_data_o;
    logic              unload_ready_i;
    logic              busy_o;
    logic              done_o;

    int                n_checks = 0;
    int                n_err    = 0;
    int                done_cnt = 0;
    logic [CW-1:0]     exp_q[$];
    logic [DW-1:0]     exp_mem[NW];
    logic [CW-1:0]     load_vals[64];
    logic              stall_seen = 1'b0;
    logic [CW-1:0]     stall_data = '0;

    always #5 clk = ~clk;

    pq_coeff_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .modulus        (modulus),
        .wdata_pq_i     (wdata_pq_i),
        .we_pq_i        (we_pq_i),
        .rdata_pq_o     (rdata_pq_o),
        .load_start_i   (load_start_i),
        .load_valid_i   (load_valid_i),
        .load_data_i    (load_data_i),
        .load_ready_o   (load_ready_o),
        .unload_start_i (unload_start_i),
        .unload_valid_o (unload_valid_o),
        .unload_data_o  (unload_data_o),
        .unload_ready_i (unload_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rword(input int i);
        return rdata_pq_o[i*DW +: DW];
    endfunction

    task automatic chk_words(input string name);
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s_word%0d", name, i), rword(i), exp_mem[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain; 1: probe early word + inject NTT write/restart mid-load;
    // 2: both starts together
    task automatic run_load(input int nbeats, input int mode);
        load_start_i   = 1'b1;
        unload_start_i = (mode == 2);
        tick();
        load_start_i   = 1'b0;
        unload_start_i = 1'b0;
        if (mode == 2) begin
            chk("both_start_load_ready", 32'(load_ready_o), 32'd1);
            chk("both_start_unload_valid", 32'(unload_valid_o), 32'd0);
        end
        if (mode == 1) begin
            chk("load_ready_in_load", 32'(load_ready_o), 32'd1);
            chk("busy_in_load", 32'(busy_o), 32'd1);
        end
        for (int b = 0; b < nbeats; b++) begin
            load_data_i  = load_vals[b];
            load_valid_i = 1'b1;
            if (mode == 1 && b == 10) begin
                we_pq_i                  = 32'h0000_0005;
                wdata_pq_i[0*DW +: DW]   = 32'hAAAA_5555;
                wdata_pq_i[2*DW +: DW]   = 32'hAAAA_5555;
                load_start_i             = 1'b1;
            end
            if (mode == 1 && b == 11) begin
                we_pq_i      = '0;
                load_start_i = 1'b0;
            end
            tick();
            if (mode == 1 && b == 1) begin
                chk("word0_after_beat2", rword(0), {load_vals[1], load_vals[0]});
            end
            if (mode == 2 && b == 30) begin
                chk("both_mid_unload_valid", 32'(unload_valid_o), 32'd0);
            end
        end
        load_valid_i = 1'b0;
    endtask

    task automatic chk_done_pulse(input string name);
        chk({name, "_done_hi"}, 32'(done_o), 32'd1);
        chk({name, "_busy_lo"}, 32'(busy_o), 32'd0);
        tick();
        chk({name, "_done_lo"}, 32'(done_o), 32'd0);
    endtask

    // Monitor: scoreboard for unload beats, hold check during stalls, done counting.
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (done_o) begin
                done_cnt++;
                chk("done_not_with_busy", 32'(busy_o), 32'd0);
            end
            if (stall_seen && unload_valid_o) begin
                chk("unload_hold_stable", 32'(unload_data_o), 32'(stall_data));
            end
            stall_seen = unload_valid_o && !unload_ready_i;
            stall_data = unload_data_o;
            if (unload_valid_o && unload_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unload_extra: got %h with no coefficient expected", unload_data_o);
                end else begin
                    chk("unload_data", 32'(unload_data_o), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_done;
        rst            = 1'b1;
        modulus        = 16'd3329;
        wdata_pq_i     = '0;
        we_pq_i        = '0;
        load_start_i   = 1'b0;
        load_valid_i   = 1'b0;
        load_data_i    = '0;
        unload_start_i = 1'b0;
        unload_ready_i = 1'b0;
        for (int i = 0; i < NW; i++) exp_mem[i] = '0;
        tick();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_load_ready", 32'(load_ready_o), 32'd0);
        chk("rst_unload_valid", 32'(unload_valid_o), 32'd0);
        chk("rst_unload_data", 32'(unload_data_o), 32'd0);
        chk_words("rst");

        // Full load of 0..63 with NTT write and restart injected mid-load
        for (int b = 0; b < 64; b++) load_vals[b] = 16'(b);
        run_load(64, 1);
        chk_done_pulse("load1");
        chk("load1_done_count", 32'(done_cnt), 32'd1);
        for (int k = 0; k < NW; k++) exp_mem[k] = {16'(2*k+1), 16'(2*k)};
        chk_words("load1");

        // Unload with ready toggling 1,0,1,0
        for (int k = 0; k < 64; k++) exp_q.push_back(16'(k));
        unload_start_i = 1'b1;
        tick();
        unload_start_i = 1'b0;
        chk("unload_valid_first", 32'(unload_valid_o), 32'd1);
        chk("unload_busy", 32'(busy_o), 32'd1);
        got_done = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            unload_ready_i = (cyc % 2 == 0);
            tick();
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
        end
        chk("unload_done_seen", 32'(got_done), 32'd1);
        chk("unload_busy_at_done", 32'(busy_o), 32'd0);
        unload_ready_i = 1'b0;
        tick();
        chk("unload_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("unload_done_count", 32'(done_cnt), 32'd2);
        chk("idle_unload_valid", 32'(unload_valid_o), 32'd0);
        chk("idle_unload_data", 32'(unload_data_o), 32'd0);

        // NTT multi-word write while idle
        for (int i = 0; i < NW; i++) wdata_pq_i[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
        wdata_pq_i[0*DW +: DW] = 32'hAAAA_5555;
        wdata_pq_i[2*DW +: DW] = 32'hAAAA_5555;
        we_pq_i = 32'h0000_0005;
        tick();
        we_pq_i = '0;
        exp_mem[0] = 32'hAAAA_5555;
        exp_mem[2] = 32'hAAAA_5555;
        chk_words("idle_write");

        // Simultaneous starts select LOAD; coefficients straddling the modulus
        load_vals[0] = 16'd3330;
        load_vals[1] = 16'd3328;
        for (int b = 2; b < 64; b++) load_vals[b] = 16'(b * 50);
        run_load(64, 2);
        chk_done_pulse("load2");
        chk("load2_done_count", 32'(done_cnt), 32'd3);
`ifdef PQ_COEFF_REDUCE_EN
        exp_mem[0] = {16'd3328, 16'd1};
`else
        exp_mem[0] = {16'd3328, 16'd3330};
`endif
        for (int k = 1; k < NW; k++) exp_mem[k] = {16'((2*k+1) * 50), 16'((2*k) * 50)};
        chk_words("load2");

        // Reset after 10 beats aborts the load and clears the array
        for (int b = 0; b < 64; b++) load_vals[b] = 16'(b + 7);
        run_load(10, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NW; i++) exp_mem[i] = '0;
        chk_words("abort");
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_load_ready", 32'(load_ready_o), 32'd0);
        tick();
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'd3);

        // Fresh full load after abort
        run_load(64, 0);
        chk_done_pulse("load3");
        chk("load3_done_count", 32'(done_cnt), 32'd4);
        for (int k = 0; k < NW; k++) exp_mem[k] = {16'(2*k+1+7), 16'(2*k+7)};
        chk_words("load3");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
